// File: rtl/attendant_call_dispatcher.sv
// Attendant-station call dispatcher: queues rising seat call lights in arrival order,
// presents the oldest one, pulses the seat's clear line on acknowledge and flags slow service.
module attendant_call_dispatcher #(
  parameter int unsigned NUM_SEATS  = 8,
  parameter int unsigned SEAT_W     = 3,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ESC_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SEATS-1:0]     seat_call,
  input  logic                     ack,
  output logic [NUM_SEATS-1:0]     seat_clear,
  output logic                     pending,
  output logic [SEAT_W-1:0]        current_seat,
  output logic [$clog2(DEPTH):0]   pending_count,
  output logic                     escalate
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned TIMER_W = $clog2(ESC_CYCLES + 1);
  localparam logic [TIMER_W-1:0] ESC_MAX = TIMER_W'(ESC_CYCLES);
  localparam logic [TIMER_W-1:0] ESC_THR = TIMER_W'(ESC_CYCLES - 1);
  localparam logic [CNT_W-1:0]   FULL    = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, PRESENT, CLEAR, SKIP} state_t;

  state_t                state_q, state_d;
  logic [NUM_SEATS-1:0]  seat_call_prev_q, seat_call_prev_d;
  logic                  ack_sync_q, ack_sync_d;
  logic                  ack_prev_q, ack_prev_d;
  logic [NUM_SEATS-1:0]  req_q, req_d;
  logic [NUM_SEATS-1:0]  queued_q, queued_d;
  logic [SEAT_W-1:0]     mem_q [DEPTH];
  logic [SEAT_W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;

  logic [NUM_SEATS-1:0]  rise;
  logic                  ack_rise;
  logic                  push, pop;
  logic [SEAT_W-1:0]     push_seat;
  logic [SEAT_W-1:0]     head;

  always_comb begin
    seat_call_prev_d = seat_call;
    ack_sync_d       = ack;
    ack_prev_d       = ack_sync_q;
    state_d          = state_q;
    queued_d         = queued_q;
    mem_d            = mem_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    timer_d          = timer_q;
    push             = 1'b0;
    push_seat        = '0;
    seat_clear       = '0;

    head     = mem_q[rd_ptr_q];
    rise     = seat_call & ~seat_call_prev_q;
    ack_rise = ack_sync_q & ~ack_prev_q;
    pop      = (state_q == CLEAR) || (state_q == SKIP);

    // Lowest-index flagged seat wins; flags simply hold while the queue is full.
    if (count_q != FULL) begin
      for (int unsigned i = 0; i < NUM_SEATS; i++) begin
        if (req_q[i] && !push) begin
          push      = 1'b1;
          push_seat = SEAT_W'(i);
        end
      end
    end

    req_d = (req_q | (rise & ~queued_q)) & seat_call;

    if (pop) begin
      queued_d[head] = 1'b0;
      rd_ptr_d       = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      req_d[push_seat]    = 1'b0;
      queued_d[push_seat] = 1'b1;
      mem_d[wr_ptr_q]     = push_seat;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (count_q != '0) state_d = PRESENT;
      end
      PRESENT: begin
        if (timer_q != ESC_MAX) timer_d = timer_q + TIMER_W'(1);
        if (!seat_call[head]) state_d = SKIP;
        else if (ack_rise)    state_d = CLEAR;
      end
      CLEAR, SKIP: begin
        timer_d = '0;
        state_d = (count_d != '0) ? PRESENT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == CLEAR) seat_clear[head] = 1'b1;
    pending       = (state_q != IDLE);
    current_seat  = pending ? head : '0;
    pending_count = count_q;
    escalate      = (state_q == PRESENT) && (timer_q >= ESC_THR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      seat_call_prev_q <= '0;
      ack_sync_q       <= 1'b0;
      ack_prev_q       <= 1'b0;
      req_q            <= '0;
      queued_q         <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      timer_q          <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q          <= state_d;
      seat_call_prev_q <= seat_call_prev_d;
      ack_sync_q       <= ack_sync_d;
      ack_prev_q       <= ack_prev_d;
      req_q            <= req_d;
      queued_q         <= queued_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      timer_q          <= timer_d;
      mem_q            <= mem_d;
    end
  end

endmodule

// File: tb/tb_attendant_call_dispatcher.sv
// Bench for attendant_call_dispatcher: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the dispatcher behaviour.
module tb_attendant_call_dispatcher;

  localparam int NS  = 8;
  localparam int DP  = 4;
  localparam int ESC = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] seat_call;
  logic          ack;
  logic [NS-1:0] seat_clear;
  logic          pending;
  logic [2:0]    current_seat;
  logic [2:0]    pending_count;
  logic          escalate;

  int n_checks = 0;
  int n_errors = 0;

  attendant_call_dispatcher #(
    .NUM_SEATS(NS), .SEAT_W(3), .DEPTH(DP), .ESC_CYCLES(ESC)
  ) dut (
    .clk(clk), .reset(reset), .seat_call(seat_call), .ack(ack),
    .seat_clear(seat_clear), .pending(pending), .current_seat(current_seat),
    .pending_count(pending_count), .escalate(escalate)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 presenting, 2 clearing, 3 skipping.
  logic [NS-1:0] m_prev, m_req, m_queued;
  bit            m_as, m_ap;
  int            m_q[$];
  int            m_mode, m_wait;

  task automatic model_step();
    logic [NS-1:0] nreq;
    int push_i, nmode, nwait;
    bit arise;
    if (reset) begin
      m_prev = '0; m_req = '0; m_queued = '0; m_as = 0; m_ap = 0;
      m_q.delete(); m_mode = 0; m_wait = 0;
      return;
    end
    arise  = m_as & ~m_ap;
    push_i = -1;
    if (m_q.size() < DP)
      for (int i = 0; i < NS; i++) if (m_req[i]) begin push_i = i; break; end
    nreq  = (m_req | (seat_call & ~m_prev & ~m_queued)) & seat_call;
    nmode = m_mode;
    nwait = m_wait;
    case (m_mode)
      0: begin nwait = 0; if (m_q.size() > 0) nmode = 1; end
      1: begin
        if (m_wait < ESC) nwait = m_wait + 1;
        if (!seat_call[m_q[0]]) nmode = 3;
        else if (arise)         nmode = 2;
      end
      default: begin m_queued[m_q[0]] = 1'b0; void'(m_q.pop_front()); nwait = 0; end
    endcase
    if (push_i >= 0) begin
      nreq[push_i] = 1'b0; m_queued[push_i] = 1'b1; m_q.push_back(push_i);
    end
    if (m_mode >= 2) nmode = (m_q.size() > 0) ? 1 : 0;
    m_req = nreq; m_mode = nmode; m_wait = nwait;
    m_prev = seat_call; m_ap = m_as; m_as = ack;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit ep;
    ep = (m_mode != 0);
    check("pending", 32'(pending), 32'(ep));
    check("current_seat", 32'(current_seat), ep ? 32'(m_q[0]) : 32'd0);
    check("seat_clear", 32'(seat_clear), (m_mode == 2) ? (32'd1 << m_q[0]) : 32'd0);
    check("pending_count", 32'(pending_count), 32'(m_q.size()));
    check("escalate", 32'(escalate), 32'((m_mode == 1) && (m_wait >= ESC - 1)));
  endtask

  task automatic step(input logic [NS-1:0] sc, input logic a, input logic r);
    seat_call = sc; ack = a; reset = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input logic [NS-1:0] sc, input logic a, input int n);
    for (int i = 0; i < n; i++) step(sc, a, 1'b0);
  endtask

  task automatic ack_pulse(input logic [NS-1:0] sc);
    step(sc, 1'b1, 1'b0);
    run(sc, 1'b0, 3);
  endtask

  initial begin
    logic [NS-1:0] r_sc;
    logic          r_ack, r_rst;

    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_count", 32'(pending_count), 32'd0);

    // Single call, ack, light stays on afterwards
    run(8'h04, 1'b0, 3);
    check("single_pending", 32'(pending), 32'd1);
    check("single_seat", 32'(current_seat), 32'd2);
    step(8'h04, 1'b1, 1'b0);
    step(8'h04, 1'b0, 1'b0);
    check("single_clear", 32'(seat_clear), 32'h04);
    step(8'h04, 1'b0, 1'b0);
    check("single_after", 32'({seat_clear, pending, pending_count}), 32'd0);
    run(8'h04, 1'b0, 4);
    run(8'h00, 1'b0, 2);

    // Simultaneous calls
    run(8'h91, 1'b0, 5);
    check("simul_count", 32'(pending_count), 32'd3);
    for (int k = 0; k < 3; k++) ack_pulse(8'h91);
    run(8'h00, 1'b0, 3);

    // Overfill
    run(8'h3F, 1'b0, 8);
    check("overfill_count", 32'(pending_count), 32'd4);
    for (int k = 0; k < 7; k++) ack_pulse(8'h3F);
    run(8'h00, 1'b0, 3);

    // Cancel while queued
    run(8'h0A, 1'b0, 5);
    step(8'h08, 1'b0, 1'b0);
    check("cancel_noclear", 32'(seat_clear), 32'd0);
    step(8'h08, 1'b0, 1'b0);
    check("cancel_next", 32'(current_seat), 32'd3);
    ack_pulse(8'h08);
    run(8'h00, 1'b0, 3);

    // Escalation, then a held ack with two calls queued
    run(8'h01, 1'b0, 2);
    run(8'h01, 1'b0, 9);
    check("esc_before", 32'(escalate), 32'd0);
    step(8'h01, 1'b0, 1'b0);
    check("esc_tenth", 32'(escalate), 32'd1);
    run(8'h01, 1'b0, 6);
    step(8'h01, 1'b1, 1'b0);
    step(8'h01, 1'b0, 1'b0);
    check("esc_clear", 32'({seat_clear, escalate}), 32'h02);
    run(8'h00, 1'b0, 2);
    run(8'h06, 1'b0, 5);
    run(8'h06, 1'b1, 20);
    check("held_ack_count", 32'(pending_count), 32'd1);
    run(8'h06, 1'b0, 2);
    ack_pulse(8'h06);
    run(8'h00, 1'b0, 3);

    // Reset mid-operation
    run(8'h2C, 1'b0, 6);
    step(8'h20, 1'b0, 1'b1);
    step(8'h20, 1'b0, 1'b1);
    check("midrst_out", 32'({seat_clear, pending, pending_count, escalate}), 32'd0);
    run(8'h20, 1'b0, 3);
    check("midrst_seat", 32'({pending, current_seat}), 32'h0D);
    ack_pulse(8'h20);
    run(8'h00, 1'b0, 3);

    // Random traffic
    r_sc = '0; r_ack = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) r_sc[$urandom_range(0, NS - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) r_ack = ~r_ack;
      r_rst = ($urandom_range(0, 299) == 0);
      step(r_sc, r_ack, r_rst);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/attendant_call_dispatcher.md
Name: attendant_call_dispatcher

Overview:
Attendant-station end of the seat call-light system. Monitors the call-light level from every seat, queues new calls in arrival order and presents the oldest pending seat to the attendant. When the attendant acknowledges, it returns a one-cycle clear pulse to that seat's cancel input. Calls left unanswered too long raise an escalation flag.

Parameters:
NUM_SEATS, 8, number of seat call lines
SEAT_W, 3, seat index width (clog2 of NUM_SEATS)
DEPTH, 4, call FIFO depth in entries (power of 2, at least 2)
ESC_CYCLES, 1000, cycles a call may be presented before escalate asserts

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
seat_call  in  NUM_SEATS  per-seat call-light level (1 = light on)
ack  in  1  attendant acknowledge button, level, edge-detected internally
seat_clear  out  NUM_SEATS  one-hot, one-cycle pulse driven to the served seat's cancel input
pending  out  1  a call is being presented
current_seat  out  SEAT_W  index of the presented seat, valid when pending=1, else 0
pending_count  out  clog2(DEPTH)+1  entries currently in the FIFO
escalate  out  1  presented call has waited at least ESC_CYCLES

Behaviour:
- Reset (synchronous): all outputs 0; FIFO empty; req flags, queued flags and timer cleared; FSM enters IDLE.
- Reset clears seat_call_prev and ack_prev to 0, so seats already lit when reset deasserts are detected as new calls.
- Rise detect: rise[i] = seat_call[i] & ~seat_call_prev[i], with seat_call_prev registered every cycle.
- Req flag: req[i] sets on rise[i] if queued[i]=0. It clears when seat_call[i] is low, or when seat i is pushed.
- Push arbitration: at most one push per cycle. Push the lowest-index seat with req=1, provided the FIFO is not full.
  - A push sets queued[i] and clears req[i].
  - While the FIFO is full, req flags hold. No call is lost.
- Duplicates: a seat is never in the FIFO twice. A re-call requires the light to go low and then high again after its entry leaves.
- FIFO: circular buffer with wrap-around pointers.
  - Push and pop in the same cycle are both allowed; pending_count is unchanged in that case.
  - pending_count tracks occupancy 0..DEPTH.
- Ack edge: ack_rise = ack & ~ack_prev. A held ack serves only one call.
- FSM states:
  - IDLE: pending=0, timer=0. Move to PRESENT when the FIFO is non-empty.
  - PRESENT: pending=1, current_seat = head; the timer increments and saturates at ESC_CYCLES. Transitions, with (1) taking priority over (2):
    1. If seat_call[head]=0 (passenger cancelled), go to SKIP.
    2. Else if ack_rise, go to CLEAR.
  - CLEAR (1 cycle): seat_clear[head]=1, pending stays 1. Pop the head, clear queued[head], timer=0, then go to PRESENT if the FIFO still has entries after the pop, else IDLE.
  - SKIP (1 cycle): no seat_clear. Pop the head, clear queued[head], timer=0, then go to PRESENT or IDLE as in CLEAR.
- escalate = 1 when state=PRESENT and timer >= ESC_CYCLES-1. It drops when the state leaves PRESENT.
- ack_rise outside PRESENT is ignored.
- Latency: with the queue empty and no other flags, if seat_call[i] is first sampled high at edge N:
  - req[i] sets at edge N;
  - the push occurs at edge N+1;
  - pending=1 and current_seat=i from edge N+2.
- Ack latency: ack first sampled high at edge M while in PRESENT → seat_clear is high for exactly the cycle after edge M+1.
- Post-clear: if the seat keeps its light on after the clear (passenger still holding call), no re-queue happens because there is no rise.
- Reset mid-operation: the queue is flushed and no seat_clear is issued. Lit seats re-queue via rise detection after reset.

Test Plan:
- Single call: reset, then seat_call=8'h04. Required: pending=1 and current_seat=2 two cycles after the first high sample. ack pulse → seat_clear=8'h04 for exactly 1 cycle, then pending=0 and pending_count=0.
- Simultaneous calls: seat_call goes 8'h00→8'h91 in one cycle. Required push order 0, 4, 7, with pending_count reaching 3. Three separate ack pulses → seat_clear=8'h01, 8'h10, 8'h80 in that order.
- Overfill with DEPTH=4: seats 0–5 rise together. Required: pending_count saturates at 4 while seats 4 and 5 stay flagged. Seats 4 and 5 are pushed as acks drain the queue. All 6 are cleared in index order, none lost.
- Cancel while queued: queue seats 1 and 3, drop seat_call[1] while seat 1 is presented. Required: SKIP with no seat_clear, then current_seat=3 one cycle later.
- Escalation with ESC_CYCLES=10: present one call and withhold ack. Required: escalate=1 from the 10th presented cycle, steady until ack. escalate=0 on the CLEAR cycle. Holding ack high 20 cycles with two queued calls serves only one.
- Reset mid-operation: reset asserted with 3 calls queued and seat 5 still lit. Required: all outputs 0 during reset, no seat_clear pulse. After release, only seat 5 re-queues and is presented 2 cycles later.
